// File: rtl/elevator_scheduler.sv
// elevator_scheduler: LOOK-sweep elevator core. Latches floor calls, moves the
// car one floor per FLOOR_TICKS ticks, holds the doors for DOOR_TICKS ticks and
// presents the current target floor and motion state to the display controller.
module elevator_scheduler #(
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_TICKS = 4,
    parameter int DOOR_TICKS  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [NUM_FLOORS-1:0]         call_req,
    output logic [NUM_FLOORS-1:0]         destination,
    output logic [1:0]                    sim_state,
    output logic [$clog2(NUM_FLOORS)-1:0] current_floor,
    output logic [NUM_FLOORS-1:0]         pending
);

    localparam int FW = $clog2(NUM_FLOORS);
    localparam int TW = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
    localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

    localparam logic [TW-1:0] TRAVEL_LAST = TW'(FLOOR_TICKS - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TICKS - 1);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_UP    = 2'b01;
    localparam logic [1:0] S_DOWN  = 2'b10;
    localparam logic [1:0] S_DOORS = 2'b11;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    logic [1:0]            state, state_d;
    logic                  last_dir, last_dir_d;
    logic [TW-1:0]         travel_cnt, travel_cnt_d;
    logic [DW-1:0]         door_cnt, door_cnt_d;
    logic [FW-1:0]         floor_d;
    logic [NUM_FLOORS-1:0] pending_d;

    logic          any_above, any_below;
    logic [FW-1:0] up_floor, down_floor;
    logic [FW-1:0] move_floor;
    logic          has_target;

    // Nearest pending floor above (lowest) and below (highest) the car.
    always_comb begin
        any_above  = 1'b0;
        any_below  = 1'b0;
        up_floor   = '0;
        down_floor = '0;
        // Descending scan: the last hit is the lowest floor above the car.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(current_floor))) begin
                any_above = 1'b1;
                up_floor  = FW'(i);
            end
        end
        // Ascending scan: the last hit is the highest floor below the car.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(current_floor))) begin
                any_below  = 1'b1;
                down_floor = FW'(i);
            end
        end
    end

    // Floor the car reaches when the current travel leg completes.
    assign move_floor = (state == S_DOWN) ? current_floor - 1'b1 : current_floor + 1'b1;
    assign has_target = (state == S_DOWN) ? any_below : any_above;

    // Next-state logic: direction choice, travel/dwell timing and request latch.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value unassigned (no latch).
        state_d      = state;
        last_dir_d   = last_dir;
        travel_cnt_d = travel_cnt;
        door_cnt_d   = door_cnt;
        floor_d      = current_floor;
        pending_d    = pending | call_req;

        case (state)
            S_IDLE: begin
                if (pending[current_floor]) begin
                    state_d                  = S_DOORS;
                    pending_d[current_floor] = 1'b0;
                end else if (any_above && (!any_below || last_dir == DIR_UP)) begin
                    state_d    = S_UP;
                    last_dir_d = DIR_UP;
                end else if (any_below) begin
                    state_d    = S_DOWN;
                    last_dir_d = DIR_DOWN;
                end
            end

            S_UP, S_DOWN: begin
                if (tick) begin
                    if (travel_cnt == TRAVEL_LAST) begin
                        travel_cnt_d = '0;
                        // A target always exists while moving; the guard only
                        // keeps the car inside the shaft should that ever break.
                        if (has_target) begin
                            floor_d = move_floor;
                            if (pending[move_floor]) begin
                                state_d               = S_DOORS;
                                pending_d[move_floor] = 1'b0;
                            end
                        end
                    end else begin
                        travel_cnt_d = travel_cnt + 1'b1;
                    end
                end
            end

            default: begin
                // Doors open: calls at this floor are absorbed.
                pending_d[current_floor] = 1'b0;
                if (tick) begin
                    if (door_cnt == DOOR_LAST) begin
                        door_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        door_cnt_d = door_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            last_dir      <= DIR_UP;
            travel_cnt    <= '0;
            door_cnt      <= '0;
            current_floor <= '0;
            pending       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed from the same pre-edge state.
            state         <= state_d;
            last_dir      <= last_dir_d;
            travel_cnt    <= travel_cnt_d;
            door_cnt      <= door_cnt_d;
            current_floor <= floor_d;
            pending       <= pending_d;
        end
    end

    // Target floor decode from registered state only.
    always_comb begin
        destination = '0;
        case (state)
            S_UP:    if (any_above) destination[up_floor] = 1'b1;
            S_DOWN:  if (any_below) destination[down_floor] = 1'b1;
            S_DOORS: destination[current_floor] = 1'b1;
            default: destination = '0;
        endcase
    end

    assign sim_state = state;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed scenarios plus random calls/ticks, checked
// by a per-cycle scoreboard fed from a floor/request-level reference model.
module tb_elevator_scheduler;

    localparam int N  = 8;
    localparam int FT = 4;
    localparam int DT = 8;

    logic         clk;
    logic         rst;
    logic         tick;
    logic [N-1:0] call_req;
    logic [N-1:0] destination;
    logic [1:0]   sim_state;
    logic [2:0]   current_floor;
    logic [N-1:0] pending;

    elevator_scheduler #(.NUM_FLOORS(N), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .call_req      (call_req),
        .destination   (destination),
        .sim_state     (sim_state),
        .current_floor (current_floor),
        .pending       (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]   st;
        logic [2:0]   fl;
        logic [N-1:0] pend;
        logic [N-1:0] dest;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: mode 0 idle, 1 up, 2 down, 3 doors; one phase timer.
    int           m_mode;
    int           m_floor;
    logic [N-1:0] m_req;
    bit           m_up;
    int           m_ticks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode  = 0;
        m_floor = 0;
        m_req   = '0;
        m_up    = 1'b1;
        m_ticks = 0;
    endfunction

    function automatic int count_above();
        int c = 0;
        for (int f = m_floor + 1; f < N; f++) if (m_req[f]) c++;
        return c;
    endfunction

    function automatic int count_below();
        int c = 0;
        for (int f = 0; f < m_floor; f++) if (m_req[f]) c++;
        return c;
    endfunction

    function automatic logic [N-1:0] model_dest();
        logic [N-1:0] d = '0;
        if (m_mode == 1) begin
            for (int f = N - 1; f > m_floor; f--) if (m_req[f]) d = '0 | (N'(1) << f);
        end else if (m_mode == 2) begin
            for (int f = 0; f < m_floor; f++) if (m_req[f]) d = '0 | (N'(1) << f);
        end else if (m_mode == 3) begin
            d[m_floor] = 1'b1;
        end
        return d;
    endfunction

    function automatic void model_step(input bit t, input logic [N-1:0] c, input bit r);
        logic [N-1:0] nreq;
        if (r) begin
            model_reset();
            return;
        end
        nreq = m_req | c;
        case (m_mode)
            0: begin
                if (m_req[m_floor]) begin
                    m_mode = 3;
                    nreq[m_floor] = 1'b0;
                end else if (count_above() > 0 && count_below() > 0) begin
                    m_mode = m_up ? 1 : 2;
                end else if (count_above() > 0) begin
                    m_mode = 1;
                    m_up   = 1'b1;
                end else if (count_below() > 0) begin
                    m_mode = 2;
                    m_up   = 1'b0;
                end
            end
            1, 2: begin
                if (t) begin
                    m_ticks++;
                    if (m_ticks == FT) begin
                        m_ticks = 0;
                        m_floor = m_floor + ((m_mode == 1) ? 1 : -1);
                        if (m_req[m_floor]) begin
                            m_mode = 3;
                            nreq[m_floor] = 1'b0;
                        end
                    end
                end
            end
            default: begin
                nreq[m_floor] = 1'b0;
                if (t) begin
                    m_ticks++;
                    if (m_ticks == DT) begin
                        m_ticks = 0;
                        m_mode  = 0;
                    end
                end
            end
        endcase
        m_req = nreq;
    endfunction

    // One clock: drive inputs, advance the model at the edge, queue expectation.
    task automatic step(input bit t, input logic [N-1:0] c);
        exp_t e;
        tick     = t;
        call_req = c;
        @(posedge clk);
        model_step(t, c, rst);
        e.st   = 2'(m_mode);
        e.fl   = 3'(m_floor);
        e.pend = m_req;
        e.dest = model_dest();
        exp_q.push_back(e);
        #1;
    endtask

    // Step with tick=1 until the DUT shows the given state (and floor if fl>=0).
    task automatic run_until(input string name, input logic [1:0] st, input int fl, input int limit);
        int n = 0;
        while (!(sim_state == st && (fl < 0 || int'(current_floor) == fl)) && n < limit) begin
            step(1'b1, '0);
            n++;
        end
        check(name, 32'(sim_state == st && (fl < 0 || int'(current_floor) == fl)), 32'd1);
    endtask

    // Monitor: compare every cycle's outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_state",   32'(sim_state),     32'(e.st));
                check("sb_floor",   32'(current_floor), 32'(e.fl));
                check("sb_pending", 32'(pending),       32'(e.pend));
                check("sb_dest",    32'(destination),   32'(e.dest));
            end
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        tick     = 1'b0;
        call_req = '0;
        model_reset();
        repeat (3) step(1'b0, '0);
        rst = 1'b0;
        check("reset_state",   32'(sim_state),     32'd0);
        check("reset_floor",   32'(current_floor), 32'd0);
        check("reset_pending", 32'(pending),       32'd0);
        check("reset_dest",    32'(destination),   32'd0);

        // Single call to floor 4.
        step(1'b1, 8'h10);
        step(1'b1, 8'h00);
        check("s1_up_state", 32'(sim_state),   32'd1);
        check("s1_up_dest",  32'(destination), 32'h10);
        repeat (4 * FT) step(1'b1, 8'h00);
        check("s1_arrive_floor",   32'(current_floor), 32'd4);
        check("s1_arrive_state",   32'(sim_state),     32'd3);
        check("s1_arrive_pending", 32'(pending),       32'd0);

        // Doors at 4, last_dir up, calls at 6 and 1.
        step(1'b0, 8'h42);
        repeat (DT) step(1'b1, 8'h00);
        check("s2_idle_state", 32'(sim_state), 32'd0);
        step(1'b1, 8'h00);
        check("s2_up_state", 32'(sim_state),   32'd1);
        check("s2_up_dest",  32'(destination), 32'h40);
        run_until("s2_reach6", 2'd3, 6, 200);
        run_until("s2_down", 2'd2, -1, 100);
        check("s2_down_dest", 32'(destination), 32'h02);

        // Retarget while moving up toward 5.
        run_until("s3_reach1", 2'd3, 1, 200);
        run_until("s3_idle1", 2'd0, -1, 50);
        step(1'b1, 8'h01);
        run_until("s3_reach0", 2'd3, 0, 200);
        run_until("s3_idle0", 2'd0, -1, 50);
        step(1'b1, 8'h20);
        step(1'b1, 8'h00);
        check("s3_dest5", 32'(destination), 32'h20);
        step(1'b1, 8'h00);
        step(1'b1, 8'h04);
        check("s3_dest2",  32'(destination),   32'h04);
        check("s3_floor0", 32'(current_floor), 32'd0);
        run_until("s3_stop2", 2'd3, 2, 200);
        run_until("s3_stop5", 2'd3, 5, 200);

        // Repeated call at the open floor is absorbed and does not extend dwell.
        run_until("s4_idle5", 2'd0, -1, 50);
        step(1'b1, 8'h08);
        run_until("s4_reach3", 2'd3, 3, 200);
        for (int i = 0; i < DT; i++) begin
            check("s4_pend3_clear", 32'(pending[3]), 32'd0);
            check("s4_doors_held",  32'(sim_state),  32'd3);
            step(1'b1, 8'h08);
        end
        check("s4_dwell_end", 32'(sim_state), 32'd0);
        step(1'b1, 8'h00);
        check("s4_pend_after", 32'(pending),   32'd0);
        check("s4_stay_idle",  32'(sim_state), 32'd0);

        // Asynchronous reset between floors 2 and 3.
        step(1'b1, 8'h01);
        run_until("s5_reach0", 2'd3, 0, 200);
        run_until("s5_idle0", 2'd0, -1, 50);
        step(1'b1, 8'h40);
        run_until("s5_at2", 2'd1, 2, 200);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        #2;
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        check("s5_async_state",   32'(sim_state),     32'd0);
        check("s5_async_floor",   32'(current_floor), 32'd0);
        check("s5_async_pending", 32'(pending),       32'd0);
        check("s5_async_dest",    32'(destination),   32'd0);
        step(1'b1, 8'h10);
        step(1'b1, 8'h00);
        rst = 1'b0;
        repeat (20) step(1'b1, 8'h00);
        check("s5_no_motion_state", 32'(sim_state),     32'd0);
        check("s5_no_motion_floor", 32'(current_floor), 32'd0);

        // tick held low while moving up toward 7.
        step(1'b1, 8'h80);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 8'h00);
            check("s6_frozen_floor", 32'(current_floor), 32'd0);
            check("s6_frozen_state", 32'(sim_state),     32'd1);
        end
        repeat (FT - 1) step(1'b1, 8'h00);
        check("s6_resume_floor", 32'(current_floor), 32'd1);
        run_until("s6_reach7", 2'd3, 7, 200);

        // Random calls and tick patterns, checked by the scoreboard.
        for (int seg = 0; seg < 8; seg++) begin
            for (int i = 0; i < 500; i++) begin
                logic [N-1:0] c;
                bit t;
                c = '0;
                if ($urandom_range(0, 5) == 0) c[$urandom_range(0, N - 1)] = 1'b1;
                if ($urandom_range(0, 40) == 0) c = N'($urandom);
                t = (seg % 2 == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
                step(t, c);
            end
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
